// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and event word for the PS/2 Set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam int         PS2_PAUSE_LEN  = 7;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
  localparam logic [7:0] PS2_ERR_LO     = 8'h00;
  localparam logic [7:0] PS2_ERR_HI     = 8'hFF;

  typedef enum logic [2:0] {
    PS2_IDLE,
    PS2_E0,
    PS2_F0,
    PS2_E0F0,
    PS2_SKIP
  } ps2_state_t;

  typedef struct packed {
    logic       extended;
    logic       pressed;
    logic [7:0] code;
  } ps2_key_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_key_event_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign rdata = mem_q[rptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) wptr_d = wptr_q + AW'(1);
    if (rd_en) rptr_d = rptr_q + AW'(1);
    if (wr_en && !rd_en)      cnt_d = cnt_q + CW'(1);
    else if (rd_en && !wr_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage carries no reset; entries are only observable once counted in.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns a Set-2 scancode byte stream into {extended, pressed, code} key events behind a FWFT FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_scancode,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_pressed,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t     state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [TW-1:0]  idle_q, idle_d;
  logic           ovf_q, ovf_d;
  logic           push;
  ps2_key_event_t ev;
  ps2_key_event_t head;
  logic           fifo_full, fifo_empty, pop;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    idle_d  = idle_q;
    push    = 1'b0;
    ev      = '{extended: 1'b0, pressed: 1'b1, code: ps2_scancode};

    if (ps2_valid) begin
      idle_d = '0;
      if (ps2_scancode == PS2_ERR_LO || ps2_scancode == PS2_ERR_HI) begin
        state_d = PS2_IDLE;
        skip_d  = '0;
      end else begin
        unique case (state_q)
          PS2_IDLE: begin
            if (ps2_scancode == PS2_EXT)        state_d = PS2_E0;
            else if (ps2_scancode == PS2_BRK)   state_d = PS2_F0;
            else if (ps2_scancode == PS2_PAUSE) begin
              state_d = PS2_SKIP;
              skip_d  = 3'(PS2_PAUSE_LEN);
            end else push = 1'b1;
          end
          PS2_E0: begin
            if (ps2_scancode == PS2_BRK) state_d = PS2_E0F0;
            else if (ps2_scancode != PS2_EXT) begin
              push        = 1'b1;
              ev.extended = 1'b1;
              state_d     = PS2_IDLE;
            end
          end
          PS2_F0: begin
            push       = 1'b1;
            ev.pressed = 1'b0;
            state_d    = PS2_IDLE;
          end
          PS2_E0F0: begin
            if (ps2_scancode != PS2_EXT) begin
              push        = 1'b1;
              ev.extended = 1'b1;
              ev.pressed  = 1'b0;
              state_d     = PS2_IDLE;
            end
          end
          PS2_SKIP: begin
            skip_d = skip_q - 3'd1;
            // Pause has no break code, so its whole 8-byte burst collapses into one make.
            if (skip_q == 3'd1) begin
              push    = 1'b1;
              ev      = '{extended: 1'b1, pressed: 1'b1, code: PS2_PAUSE_CODE};
              state_d = PS2_IDLE;
            end
          end
          default: begin
            state_d = PS2_IDLE;
            skip_d  = '0;
          end
        endcase
      end
    end else if (state_q != PS2_IDLE) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = PS2_IDLE;
        skip_d  = '0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  assign pop   = key_valid && key_ready;
  assign ovf_d = ovf_q || (push && fifo_full && !pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PS2_IDLE;
      skip_q  <= '0;
      idle_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      idle_q  <= idle_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH(PS2_EVENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(ev),
    .full (fifo_full),
    .pop  (pop),
    .rdata(head),
    .empty(fifo_empty)
  );

  // Head fields are masked so an empty FIFO presents zeros rather than stale storage.
  assign key_valid    = !fifo_empty;
  assign key_code     = fifo_empty ? 8'h00 : head.code;
  assign key_extended = !fifo_empty && head.extended;
  assign key_pressed  = !fifo_empty && head.pressed;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: prefixes, Pause, errors, timeout, overflow and mid-sequence reset.
module tb_ps2_key_decoder;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_valid;
  logic [7:0] ps2_scancode;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_pressed;
  logic       overflow;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_valid   (ps2_valid),
    .ps2_scancode(ps2_scancode),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_pressed (key_pressed),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte for exactly one clock; returns at the negedge after it was sampled.
  task automatic send(input logic [7:0] b);
    ps2_valid    = 1'b1;
    ps2_scancode = b;
    @(negedge clk);
    ps2_valid    = 1'b0;
    ps2_scancode = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_ev(input string tag, input logic [7:0] code, input logic ext, input logic pr);
    chk({tag, ".valid"}, 32'(key_valid), 32'd1);
    chk({tag, ".code"},  32'(key_code), 32'(code));
    chk({tag, ".ext"},   32'(key_extended), 32'(ext));
    chk({tag, ".press"}, 32'(key_pressed), 32'(pr));
  endtask

  task automatic expect_none(input string tag);
    chk({tag, ".none"}, 32'(key_valid), 32'd0);
  endtask

  logic [7:0] ovf_codes [DEPTH+1];

  initial begin
    ovf_codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    rst          = 1'b1;
    ps2_valid    = 1'b0;
    ps2_scancode = 8'h00;
    key_ready    = 1'b1;
    idle(3);
    chk("rst.valid", 32'(key_valid), 32'd0);
    chk("rst.code",  32'(key_code), 32'd0);
    chk("rst.ext",   32'(key_extended), 32'd0);
    chk("rst.press", 32'(key_pressed), 32'd0);
    chk("rst.ovf",   32'(overflow), 32'd0);
    rst = 1'b0;
    idle(2);

    // Plain make, then break; each event visible the cycle after its final byte and popped next edge.
    send(8'h1C);               expect_ev("make1c", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);            expect_none("make1c.pop");
    send(8'hF0);               expect_none("f0.prefix");
    send(8'h1C);               expect_ev("brk1c", 8'h1C, 1'b0, 1'b0);
    @(negedge clk);            expect_none("brk1c.pop");

    // Extended make / break.
    send(8'hE0);               expect_none("e0.prefix");
    send(8'h75);               expect_ev("make_e075", 8'h75, 1'b1, 1'b1);
    @(negedge clk);
    send(8'hE0);
    send(8'hF0);               expect_none("e0f0.prefix");
    send(8'h75);               expect_ev("brk_e075", 8'h75, 1'b1, 1'b0);
    @(negedge clk);

    // Pause burst back-to-back collapses to one synthetic make; 1C follows it.
    key_ready = 1'b0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    expect_none("pause.partial");
    send(8'h77);               expect_ev("pause", 8'h77, 1'b1, 1'b1);
    send(8'h1C);
    key_ready = 1'b1;
    @(negedge clk);            expect_ev("after_pause", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);            expect_none("pause.drained");

    // Stale E0 abandoned by timeout.
    send(8'hE0);
    idle(TIMEOUT + 5);
    send(8'h1C);               expect_ev("timeout", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);

    // Error byte clears pending E0.
    send(8'hE0);
    send(8'h00);               expect_none("err00");
    send(8'h1C);               expect_ev("after_err", 8'h1C, 1'b0, 1'b1);
    @(negedge clk);

    // Overflow: DEPTH+1 makes with consumer stalled.
    key_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(ovf_codes[i]);
    chk("ovf.before", 32'(overflow), 32'd0);
    send(ovf_codes[DEPTH]);
    chk("ovf.set", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      expect_ev($sformatf("drain%0d", i), ovf_codes[i], 1'b0, 1'b1);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
    end
    expect_none("drain.empty");
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // Reset in the middle of E0 F0.
    key_ready = 1'b1;
    send(8'hE0);
    ps2_valid    = 1'b1;
    ps2_scancode = 8'hF0;
    #2 rst = 1'b1;
    @(negedge clk);
    ps2_valid = 1'b0;
    chk("mrst.valid", 32'(key_valid), 32'd0);
    chk("mrst.code",  32'(key_code), 32'd0);
    chk("mrst.ovf",   32'(overflow), 32'd0);
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    send(8'h2D);               expect_ev("post_rst", 8'h2D, 1'b0, 1'b1);
    @(negedge clk);            expect_none("post_rst.pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream of the PS/2 frame receiver, this block turns the raw Set-2 scancode byte stream (one-cycle `ps2_valid` strobes) into complete key events. Each event carries the key code, an extended flag and a pressed/released flag. Events are buffered in a small FIFO and presented on a valid/ready port to the consumer logic (game, display, sound labs). The block handles E0/F0 prefixes, the 8-byte Pause sequence, line-error bytes and stale prefixes.

## Interface
- `DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 2_500_000: idle clock cycles after which a pending prefix is abandoned (50 ms at 50 MHz).
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ps2_valid`  in  1  one-cycle strobe: `ps2_scancode` holds a new byte.
- `ps2_scancode`  in  8  received byte; sampled only when `ps2_valid` is high.
- `key_valid`  out  1  FIFO head holds an event.
- `key_ready`  in  1  consumer accepts the head; a pop occurs when `key_valid && key_ready`.
- `key_code`  out  8  make code of the head event, with prefixes stripped.
- `key_extended`  out  1  head event was E0-prefixed.
- `key_pressed`  out  1  1 = make, 0 = break (F0).
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- Prefix FSM states: IDLE, E0, F0, E0F0, SKIP. Transitions apply only on cycles with `ps2_valid` high.
  - IDLE: E0→E0; F0→F0; E1→SKIP with skip counter = 7; any other byte emits {code, ext=0, pressed=1} and stays in IDLE.
  - E0: F0→E0F0; any other byte emits {code, ext=1, pressed=1}, then IDLE.
  - F0: any byte emits {code, ext=0, pressed=0}, then IDLE.
  - E0F0: any byte emits {code, ext=1, pressed=0}, then IDLE.
  - SKIP: each byte decrements the counter. The byte that takes the counter to 0 emits {8'h77, ext=1, pressed=1} (Pause, synthetic), then IDLE. No break event is produced for Pause.
- Error bytes 00 and FF: in any state they are dropped, emit nothing, and force IDLE (the SKIP counter is cleared).
- Prefix bytes are never emitted. E0 arriving in state E0 or E0F0 stays in the same state. F0 arriving in F0 or E0F0 emits F0 as a code; this is well-defined and harmless.
- Timeout: an idle counter increments every cycle while the FSM is not in IDLE and clears on `ps2_valid`. Reaching `TIMEOUT_CYCLES` forces IDLE and emits nothing.
- Event word is 10 bits: {extended, pressed, code}.
- FIFO is first-word-fall-through. Head fields are valid whenever `key_valid` is high and hold stable until popped.
- Full FIFO: a push is dropped and `overflow` is set. Exception: if a pop happens in the same cycle, the push is accepted and the count is unchanged.
- Empty FIFO: a pop request is ignored. A push while empty makes `key_valid` high on the next cycle.
- `overflow` clears only on `rst`.

## Timing
- Reset (async assert, synchronous release to `clk`):
  - FSM returns to IDLE; skip and timeout counters are 0.
  - FIFO is emptied.
  - `key_valid`=0, `key_code`=8'h00, `key_extended`=0, `key_pressed`=0, `overflow`=0.
- Reset mid-sequence discards any partial prefix. No event is emitted for bytes received before the reset.
- Latency: the final byte's `ps2_valid` in cycle N gives `key_valid`=1 in cycle N+1 if the FIFO was empty.
- Throughput: one push and one pop per cycle. Back-to-back `ps2_valid` strobes in consecutive cycles must be accepted.
- Count arithmetic: count width is $clog2(DEPTH)+1. Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Structure
- Package `ps2_pkg` holds:
  - constants `PS2_EXT`=8'hE0, `PS2_BRK`=8'hF0, `PS2_PAUSE`=8'hE1, `PS2_PAUSE_LEN`=7, `PS2_PAUSE_CODE`=8'h77;
  - typedef `ps2_state_t` (the FSM enum);
  - packed struct `ps2_key_event_t` {extended, pressed, code[7:0]}.
- Sub-module `ps2_event_fifo`: generic synchronous FWFT FIFO with parameters `WIDTH`/`DEPTH`, ports push/full/pop/empty, and `clk`/`rst` with the same reset rule. The FSM, timeout and overflow logic stay in `ps2_key_decoder`.

## Test plan
- Bytes 1C; F0 1C, with `key_ready`=1 → two events: {1C, ext0, press1}, then {1C, ext0, press0}. Each `key_valid` rises one cycle after its final byte.
- Bytes E0 75; E0 F0 75 → {75, ext1, press1}, then {75, ext1, press0}. No event appears for the prefix bytes.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 1C → exactly {77, ext1, press1}, then {1C, ext0, press1}.
- E0, followed by `TIMEOUT_CYCLES` idle cycles, then 1C → {1C, ext0, press1}; extended must be 0. Also: E0 00 1C → {1C, ext0, press1}.
- `key_ready`=0, then DEPTH+1 make codes 16,1E,… → `overflow`=1 and the FIFO holds the first DEPTH events. Draining returns them in order; the last one is dropped.
- `rst` asserted mid-way through E0 F0, then 2D → {2D, ext0, press1}. All outputs read 0 during reset.
